alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with these ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 instr_valid  in  1  instruction offered; instr_ready  out  1  sequencer can accept; instr  in  32  RV32I instruction word.
REQ-003 rs1_data  in  32  source operand 1; rs2_data  in  32  source operand 2. Both are sampled together with instr.
REQ-004 alu_A  out  32  and alu_B  out  32  drive the ALU operands; ALU_control  out  7  drives the ALU operation code.
REQ-005 ALU_result  in  32  ALU output; zero, negative, overflow  in  1 each  ALU flags (zero = A==B, negative = unsigned A<B).
REQ-006 res_valid  out  1  result available; res_ready  in  1  consumer accepts; res_data  out  32  result; res_overflow  out  1  captured overflow; res_illegal  out  1  instruction not decodable; br_taken  out  1  branch condition true.

Function
REQ-007 ALU_control codes SHALL be: ADD 0011100, SUB 0011101, SLL 0011110, SLT 0011111, SLTU 0100000, XOR 0100001, SRL 0100010, SRA 0100011, OR 0100100, AND 0100101. The idle code SHALL be 0000000.
REQ-008 The FSM states SHALL be IDLE, DECODE, EXEC and RESP. Transitions: IDLE->DECODE on instr_valid&&instr_ready; DECODE->EXEC if legal, else DECODE->RESP; EXEC->RESP always; RESP->IDLE on res_ready.
REQ-009 instr_ready SHALL be 1 only in IDLE, and instr, rs1_data and rs2_data SHALL be registered on the accepting edge.
REQ-010 Opcode 0110011 (R-type) SHALL map as follows: funct3 000 with funct7 0000000 -> ADD, with funct7 0100000 -> SUB; 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR; 101 with funct7 0000000 -> SRL, with funct7 0100000 -> SRA; 110 -> OR; 111 -> AND. alu_B SHALL be rs2.
REQ-011 Opcode 0010011 (I-type) SHALL use the same funct3 map with alu_B = sign-extended instr[31:20]; SUB is not valid here. For shifts, alu_B SHALL be zero-extended instr[24:20], and funct7 SHALL be 0000000 (SLLI/SRLI) or 0100000 (SRAI, funct3 101 only).
REQ-012 Any other opcode, funct3 or funct7 combination SHALL be illegal.
REQ-013 alu_A, alu_B and ALU_control SHALL be registered at the end of DECODE and held stable throughout EXEC. Outside EXEC, ALU_control SHALL be 0000000 and alu_A/alu_B SHALL be 0.
REQ-014 At the end of EXEC, the block SHALL capture ALU_result into res_data and overflow into res_overflow, but only when the code is ADD; otherwise res_overflow SHALL be 0.
REQ-015 res_valid SHALL be 1 only in RESP, and res_data, res_overflow, res_illegal and br_taken SHALL be held stable while res_valid=1 && res_ready=0.
REQ-016 Latency: with res_ready held at 1, res_valid SHALL rise 3 cycles after the accept edge (2 cycles if illegal), and the minimum issue interval SHALL be 4 cycles.
REQ-017 An illegal instruction SHALL give res_illegal=1, res_data=0, br_taken=0, and the ALU SHALL never be driven.
REQ-018 An instr_valid that is asserted while not in IDLE SHALL be ignored, with no side effects; there is no back-to-back acceptance in the RESP->IDLE cycle.

Reset
REQ-019 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 except instr_ready=1 once in IDLE; the first post-reset cycle SHALL show instr_ready=1.
REQ-020 A reset in any state SHALL abandon the operation in flight, and no res_valid SHALL be produced for it.

Configuration
REQ-021 Macro ALU_OP_SEQUENCER_BRANCH_EVAL_EN: when defined, opcode 1100011 SHALL be legal, issuing SUB with alu_A=rs1 and alu_B=rs2, and setting res_data=ALU_result.
REQ-022 In that mode br_taken SHALL be: BEQ(000)=zero; BNE(001)=!zero; BLT(100)=negative^(rs1[31]^rs2[31]); BGE(101)=its inverse; BLTU(110)=negative; BGEU(111)=!negative. funct3 010 and 011 SHALL be illegal.
REQ-023 When the macro is undefined, opcode 1100011 SHALL be illegal and br_taken SHALL be tied to 0.

Verification
REQ-024 Reset-then-ADD: after rst_n low for 2 cycles, send add with rs1=5, rs2=7, res_ready=1 -> res_valid 3 cycles after accept, res_data=12, res_overflow=0, res_illegal=0.
REQ-025 Overflow and backpressure: addi x,0x7FFFFFFF,1 with res_ready=0 for 5 cycles -> ALU_control=0011100 and alu_B=1 in EXEC; res_data=0x80000000 and res_overflow=1 held stable until res_ready rises.
REQ-026 Shifts: srai with rs1=0xF0000000, shamt 4 -> ALU_control=0100011 and alu_B=4; slli with funct7 0100000 -> res_illegal=1, res_data=0, ALU_control stays 0000000.
REQ-027 Branch (macro on): blt with rs1=0xFFFFFFFF, rs2=1 -> br_taken=1; bltu with the same operands -> br_taken=0; beq with 9/9 -> br_taken=1. Macro off: beq -> res_illegal=1.
REQ-028 Mid-operation reset and ignore: assert rst_n=0 during EXEC -> no res_valid, instr_ready=1 the next cycle; instr_valid pulsed during DECODE -> no second result.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-side bus of alu_op_sequencer; slave = sequencer,
// master = the surrounding issue logic, ALU and result consumer.
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [6:0]  ALU_control;
  logic [31:0] ALU_result;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_overflow;
  logic        res_illegal;
  logic        br_taken;

  modport master (
    output instr_valid, instr, rs1_data, rs2_data, res_ready,
           ALU_result, zero, negative, overflow,
    input  instr_ready, alu_A, alu_B, ALU_control,
           res_valid, res_data, res_overflow, res_illegal, br_taken
  );

  modport slave (
    input  instr_valid, instr, rs1_data, rs2_data, res_ready,
           ALU_result, zero, negative, overflow,
    output instr_ready, alu_A, alu_B, ALU_control,
           res_valid, res_data, res_overflow, res_illegal, br_taken
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// RV32I R/I-type ALU op sequencer: IDLE->DECODE->EXEC->RESP around an external ALU.
// Define ALU_OP_SEQUENCER_BRANCH_EVAL_EN to also evaluate conditional branches.
module alu_op_sequencer (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_ADD  = 7'b0011100;
  localparam logic [6:0] C_SUB  = 7'b0011101;
  localparam logic [6:0] C_SLL  = 7'b0011110;
  localparam logic [6:0] C_SLT  = 7'b0011111;
  localparam logic [6:0] C_SLTU = 7'b0100000;
  localparam logic [6:0] C_XOR  = 7'b0100001;
  localparam logic [6:0] C_SRL  = 7'b0100010;
  localparam logic [6:0] C_SRA  = 7'b0100011;
  localparam logic [6:0] C_OR   = 7'b0100100;
  localparam logic [6:0] C_AND  = 7'b0100101;

  state_t      state, state_nx;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [11:0] hi_q;
  logic [31:0] rs1_q, rs2_q;
  logic [6:0]  f7;

  logic        dec_legal;
  logic [6:0]  dec_ctrl;
  logic [31:0] dec_b;

  logic [31:0] a_q, b_q;
  logic [6:0]  ctrl_q;
  logic [31:0] res_q;
  logic        ovf_q, ill_q, br_q;

  assign f7 = hi_q[11:5];

  // alt selects SUB/SRA; legality of alt is checked by the caller
  function automatic logic [6:0] base_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_code = alt ? C_SUB : C_ADD;
      3'b001:  base_code = C_SLL;
      3'b010:  base_code = C_SLT;
      3'b011:  base_code = C_SLTU;
      3'b100:  base_code = C_XOR;
      3'b101:  base_code = alt ? C_SRA : C_SRL;
      3'b110:  base_code = C_OR;
      default: base_code = C_AND;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = C_IDLE;
    dec_b     = rs2_q;
    case (op_q)
      OP_R: begin
        dec_legal = (f7 == F7_BASE) ||
                    (f7 == F7_ALT && (f3_q == 3'b000 || f3_q == 3'b101));
        dec_ctrl  = base_code(f3_q, f7[5]);
      end
      OP_I: begin
        if (f3_q == 3'b001 || f3_q == 3'b101) begin
          dec_b     = {27'd0, hi_q[4:0]};
          dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT && f3_q == 3'b101);
          dec_ctrl  = base_code(f3_q, f7[5]);
        end else begin
          dec_b     = {{20{hi_q[11]}}, hi_q};
          dec_legal = 1'b1;
          dec_ctrl  = base_code(f3_q, 1'b0);
        end
      end
`ifdef ALU_OP_SEQUENCER_BRANCH_EVAL_EN
      7'b1100011: begin
        dec_legal = (f3_q != 3'b010) && (f3_q != 3'b011);
        dec_ctrl  = C_SUB;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_OP_SEQUENCER_BRANCH_EVAL_EN
  logic br_eval, slt;
  // signed A<B from the unsigned borrow and the operand sign bits
  assign slt = bus.negative ^ (rs1_q[31] ^ rs2_q[31]);
  always_comb begin
    br_eval = 1'b0;
    if (op_q == 7'b1100011) begin
      case (f3_q)
        3'b000:  br_eval = bus.zero;
        3'b001:  br_eval = !bus.zero;
        3'b100:  br_eval = slt;
        3'b101:  br_eval = !slt;
        3'b110:  br_eval = bus.negative;
        3'b111:  br_eval = !bus.negative;
        default: br_eval = 1'b0;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.instr_ready = 1'b0;
    bus.res_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nx = DECODE;
      end
      DECODE: state_nx = dec_legal ? EXEC : RESP;
      EXEC:   state_nx = RESP;
      RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      f3_q   <= '0;
      hi_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= C_IDLE;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
      br_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.instr_valid) begin
        op_q  <= bus.instr[6:0];
        f3_q  <= bus.instr[14:12];
        hi_q  <= bus.instr[31:20];
        rs1_q <= bus.rs1_data;
        rs2_q <= bus.rs2_data;
      end
      // ALU operands live only for the single EXEC cycle
      if (state == DECODE && dec_legal) begin
        a_q    <= rs1_q;
        b_q    <= dec_b;
        ctrl_q <= dec_ctrl;
      end else begin
        a_q    <= '0;
        b_q    <= '0;
        ctrl_q <= C_IDLE;
      end
      case (state)
        IDLE: begin
          res_q <= '0;
          ovf_q <= 1'b0;
          ill_q <= 1'b0;
          br_q  <= 1'b0;
        end
        DECODE: if (!dec_legal) begin
          res_q <= '0;
          ovf_q <= 1'b0;
          ill_q <= 1'b1;
          br_q  <= 1'b0;
        end
        EXEC: begin
          res_q <= bus.ALU_result;
          ovf_q <= (ctrl_q == C_ADD) && bus.overflow;
          ill_q <= 1'b0;
`ifdef ALU_OP_SEQUENCER_BRANCH_EVAL_EN
          br_q  <= br_eval;
`else
          br_q  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_A        = a_q;
  assign bus.alu_B        = b_q;
  assign bus.ALU_control  = ctrl_q;
  assign bus.res_data     = res_q;
  assign bus.res_overflow = ovf_q;
  assign bus.res_illegal  = ill_q;
  assign bus.br_taken     = br_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the bus.
// Build with ALU_OP_SEQUENCER_BRANCH_EVAL_EN to run the branch vectors.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference ALU driven from the sequencer's operand outputs
  always_comb begin
    logic [31:0] a, b, r;
    a = bus.alu_A;
    b = bus.alu_B;
    r = '0;
    bus.overflow = 1'b0;
    case (bus.ALU_control)
      7'b0011100: begin r = a + b; bus.overflow = (a[31] == b[31]) && (r[31] != a[31]); end
      7'b0011101: begin r = a - b; bus.overflow = (a[31] != b[31]) && (r[31] != a[31]); end
      7'b0011110: r = a << b[4:0];
      7'b0011111: r = {31'd0, $signed(a) < $signed(b)};
      7'b0100000: r = {31'd0, a < b};
      7'b0100001: r = a ^ b;
      7'b0100010: r = a >> b[4:0];
      7'b0100011: r = $unsigned($signed(a) >>> b[4:0]);
      7'b0100100: r = a | b;
      7'b0100101: r = a & b;
      default:    r = '0;
    endcase
    bus.ALU_result = r;
    bus.zero       = (a == b);
    bus.negative   = (a < b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // offer at a negedge in IDLE; returns at the negedge of the DECODE cycle
  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bus.instr_valid = 1'b1;
    bus.instr       = i;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    chk("instr_ready_idle", {31'd0, bus.instr_ready}, 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rs1_data    = '0;
    bus.rs2_data    = '0;
    bus.res_ready   = 1'b1;
    rst_n           = 1'b0;

    // reset held for two edges
    cyc(2);
    chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_res_valid",   {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_data",    bus.res_data, 32'd0);
    chk("rst_alu_ctrl",    {25'd0, bus.ALU_control}, 32'd0);
    chk("rst_alu_a",       bus.alu_A, 32'd0);
    chk("rst_flags",       {29'd0, bus.res_overflow, bus.res_illegal, bus.br_taken}, 32'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);

    // add x3,x1,x2 : 5+7
    send(32'h002081B3, 32'd5, 32'd7);
    chk("add_dec_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("add_dec_ctrl",  {25'd0, bus.ALU_control}, 32'd0);
    cyc(1);
    chk("add_ex_ctrl",  {25'd0, bus.ALU_control}, 32'h1C);
    chk("add_ex_a",     bus.alu_A, 32'd5);
    chk("add_ex_b",     bus.alu_B, 32'd7);
    chk("add_ex_valid", {31'd0, bus.res_valid}, 32'd0);
    cyc(1);
    chk("add_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("add_data",  bus.res_data, 32'd12);
    chk("add_ovf",   {31'd0, bus.res_overflow}, 32'd0);
    chk("add_ill",   {31'd0, bus.res_illegal}, 32'd0);
    chk("add_resp_ctrl", {25'd0, bus.ALU_control}, 32'd0);
    cyc(1);
    chk("add_done_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("add_done_ready", {31'd0, bus.instr_ready}, 32'd1);

    // addi x1,x1,1 on 0x7FFFFFFF with the consumer stalled
    bus.res_ready = 1'b0;
    send(32'h00108093, 32'h7FFF_FFFF, 32'd0);
    cyc(1);
    chk("addi_ex_ctrl", {25'd0, bus.ALU_control}, 32'h1C);
    chk("addi_ex_b",    bus.alu_B, 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("addi_hold_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("addi_hold_data",  bus.res_data, 32'h8000_0000);
      chk("addi_hold_ovf",   {31'd0, bus.res_overflow}, 32'd1);
      chk("addi_hold_ready", {31'd0, bus.instr_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    cyc(1);
    chk("addi_done_valid", {31'd0, bus.res_valid}, 32'd0);

    // srai x1,x1,4 on 0xF0000000
    send(32'h4040D093, 32'hF000_0000, 32'd0);
    cyc(1);
    chk("srai_ctrl", {25'd0, bus.ALU_control}, 32'h23);
    chk("srai_a",    bus.alu_A, 32'hF000_0000);
    chk("srai_b",    bus.alu_B, 32'd4);
    cyc(1);
    chk("srai_data", bus.res_data, 32'hFF00_0000);
    chk("srai_ovf",  {31'd0, bus.res_overflow}, 32'd0);
    cyc(1);

    // slli with funct7 0100000 is illegal: result two cycles after accept
    send(32'h40409093, 32'd1, 32'd0);
    chk("slli_bad_dec_ctrl", {25'd0, bus.ALU_control}, 32'd0);
    cyc(1);
    chk("slli_bad_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("slli_bad_ill",   {31'd0, bus.res_illegal}, 32'd1);
    chk("slli_bad_data",  bus.res_data, 32'd0);
    chk("slli_bad_br",    {31'd0, bus.br_taken}, 32'd0);
    chk("slli_bad_ctrl",  {25'd0, bus.ALU_control}, 32'd0);
    cyc(1);

    // sub 0x80000000-1: ALU flags overflow, but it is not an ADD
    send(32'h402081B3, 32'h8000_0000, 32'd1);
    cyc(1);
    chk("sub_ctrl", {25'd0, bus.ALU_control}, 32'h1D);
    cyc(1);
    chk("sub_data", bus.res_data, 32'h7FFF_FFFF);
    chk("sub_ovf",  {31'd0, bus.res_overflow}, 32'd0);
    cyc(1);

    // funct7 0000001 (mul) is illegal
    send(32'h022081B3, 32'd3, 32'd4);
    cyc(1);
    chk("mul_ill",   {31'd0, bus.res_illegal}, 32'd1);
    chk("mul_valid", {31'd0, bus.res_valid}, 32'd1);
    cyc(1);

`ifdef ALU_OP_SEQUENCER_BRANCH_EVAL_EN
    // blt -1,1 -> taken
    send(32'h0020C063, 32'hFFFF_FFFF, 32'd1);
    cyc(1);
    chk("blt_ctrl", {25'd0, bus.ALU_control}, 32'h1D);
    chk("blt_b",    bus.alu_B, 32'd1);
    cyc(1);
    chk("blt_br",   {31'd0, bus.br_taken}, 32'd1);
    chk("blt_data", bus.res_data, 32'hFFFF_FFFE);
    chk("blt_ill",  {31'd0, bus.res_illegal}, 32'd0);
    cyc(1);
    // bltu 0xFFFFFFFF,1 -> not taken
    send(32'h0020E063, 32'hFFFF_FFFF, 32'd1);
    cyc(2);
    chk("bltu_br", {31'd0, bus.br_taken}, 32'd0);
    cyc(1);
    // beq 9,9 -> taken
    send(32'h00208063, 32'd9, 32'd9);
    cyc(2);
    chk("beq_br",   {31'd0, bus.br_taken}, 32'd1);
    chk("beq_data", bus.res_data, 32'd0);
    cyc(1);
`else
    send(32'h00208063, 32'd9, 32'd9);
    cyc(1);
    chk("beq_off_ill",   {31'd0, bus.res_illegal}, 32'd1);
    chk("beq_off_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("beq_off_br",    {31'd0, bus.br_taken}, 32'd0);
    cyc(1);
`endif

    // reset during EXEC abandons the op
    send(32'h002081B3, 32'd1, 32'd1);
    cyc(1);
    chk("mid_rst_ex_ctrl", {25'd0, bus.ALU_control}, 32'h1C);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_rst_ctrl",  {25'd0, bus.ALU_control}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("mid_rst_no_valid", {31'd0, bus.res_valid}, 32'd0);
    end

    // instr_valid during DECODE is ignored
    send(32'h002081B3, 32'd1, 32'd2);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h402081B3;
    bus.rs1_data    = 32'd100;
    bus.rs2_data    = 32'd50;
    cyc(1);
    bus.instr_valid = 1'b0;
    chk("ign_ex_a",    bus.alu_A, 32'd1);
    chk("ign_ex_b",    bus.alu_B, 32'd2);
    chk("ign_ex_ctrl", {25'd0, bus.ALU_control}, 32'h1C);
    cyc(1);
    chk("ign_data",  bus.res_data, 32'd3);
    chk("ign_valid", {31'd0, bus.res_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("ign_no_second", {31'd0, bus.res_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
